uart_link_pack24: RTL and testbench
===================================

// Module: uart_link_pack24
// PURPOSE
// UART link front end: serial transmitter, serial receiver and an 8-to-24-bit packer in one block.
// Bytes arriving on rx_in are framed 8N1, offered on a valid/ready port and packed three at a
// time into a 24-bit word with a one-cycle load strobe, which drives a 24-bit payload consumer.
// The transmitter sends bytes from a valid/ready port as 8N1 frames on tx_out.
// PARAMETERS
// CLOCK_RATE  10000  clk frequency in Hz
// BAUD_RATE   300    line rate in bit/s; BIT_CYC = CLOCK_RATE/BAUD_RATE (integer division, 33 at defaults)
// PORTS
// clk       in   1   single clock, all logic on rising edge
// reset     in   1   asynchronous, active-high reset
// enable    in   1   1 = TX and RX operate; 0 = both hold idle (frame in progress is completed)
// tx_valid  in   1   tx_in holds a byte to send
// tx_in     in   8   byte to send
// tx_ready  out  1   transmitter idle, can accept a byte
// tx_out    out  1   serial output, idle high
// rx_in     in   1   serial input, idle high
// rx_ready  in   1   consumer accepts rx_out
// rx_out    out  8   last received byte
// rx_valid  out  1   rx_out holds an unconsumed byte
// rx_ovr    out  1   sticky: a byte completed while rx_valid was already high
// po        out  24  packed word, first byte in [23:16], second [15:8], third [7:0]
// ld        out  1   one-cycle strobe: po holds a new complete word
// BEHAVIOUR
// Reset values: tx_out=1, tx_ready=1, rx_valid=0, rx_out=0, rx_ovr=0, po=0, ld=0; all counters 0.
// Reset mid-frame aborts the frame immediately; tx_out returns high asynchronously.
// TX FSM IDLE->START->DATA->STOP->IDLE. In IDLE with enable, tx_valid&&tx_ready latches tx_in,
//  tx_ready drops the next cycle. START drives 0 for BIT_CYC cycles, DATA drives bits 0..7 (LSB
//  first) BIT_CYC cycles each, STOP drives 1 for BIT_CYC cycles; tx_ready rises the cycle after STOP ends.
// tx_valid while tx_ready=0 is ignored (no queue). Frame length = 10*BIT_CYC cycles.
// RX: rx_in passes through a 2-flop synchroniser. FSM IDLE->START->DATA->STOP->IDLE.
//  IDLE: synchronised falling edge -> START. START: after BIT_CYC/2 cycles sample; if high, false
//  start -> IDLE; else DATA. DATA: sample every BIT_CYC cycles, 8 bits shifted in LSB first.
//  STOP: sample after BIT_CYC; if 1, byte accepted; if 0 (framing error), byte discarded; -> IDLE.
// Accepted byte: rx_out<=byte, rx_valid<=1 next cycle; if rx_valid already 1, rx_out is
//  overwritten and rx_ovr set (cleared only by reset).
// rx_valid clears the cycle after rx_valid&&rx_ready; same-cycle accept and new byte: new byte wins,
//  rx_valid stays 1, no overrun.
// Packer: captures rx_out on each rising edge of rx_valid (0->1; held-high valid counts once).
//  2-bit count 0..2: byte k goes to po slice k ([23:16],[15:8],[7:0]); po slices update as captured.
//  On the third byte, ld=1 for exactly one cycle in which po holds all three bytes; count -> 0.
//  po holds its value until overwritten; no timeout on partial words.
// TESTING
// T1 reset then tx_in=0xAA, tx_valid 1 cycle -> tx_out: 0, then 0,1,0,1,0,1,0,1, then 1; 33 cyc/bit; tx_ready low 330 cyc.
// T2 loopback tx_out->rx_in, send 0xAA,0x01,0xAA with rx_ready=1 -> rx_valid pulses, rx_out 0xAA/0x01/0xAA;
//    single ld pulse with po=0xAA01AA.
// T3 rx_ready=0, two bytes 0x55,0x33 -> rx_valid stays 1, rx_out=0x33, rx_ovr=1, packer counts only one byte.
// T4 rx_in stop bit forced 0 on byte 0x12 -> no rx_valid, packer count unchanged.
// T5 tx_valid asserted mid-frame with 0xFF -> ignored, current frame unchanged, tx_ready stays 0.
// T6 reset asserted mid TX and mid RX frame -> tx_out=1, tx_ready=1, rx_valid=0, po=0, packer count 0.

Source files
------------

// File: rtl/uart_link_pack24_if.sv
// Handshake and payload bundle for the UART link front end.
// The slave side is the link block; the master side is the host/consumer.
interface uart_link_pack24_if;
  logic        tx_valid;
  logic [7:0]  tx_in;
  logic        tx_ready;
  logic        rx_ready;
  logic [7:0]  rx_out;
  logic        rx_valid;
  logic        rx_ovr;
  logic [23:0] po;
  logic        ld;

  modport master (
    output tx_valid, tx_in, rx_ready,
    input  tx_ready, rx_out, rx_valid, rx_ovr, po, ld
  );

  modport slave (
    input  tx_valid, tx_in, rx_ready,
    output tx_ready, rx_out, rx_valid, rx_ovr, po, ld
  );
endinterface

// File: rtl/uart_link_pack24.sv
// UART link front end: 8N1 transmitter, 8N1 receiver with 2-flop synchroniser,
// and a packer that assembles three received bytes into a 24-bit word.
module uart_link_pack24 #(
  parameter int CLOCK_RATE = 10000,
  parameter int BAUD_RATE  = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic rx_in,
  output logic tx_out,
  uart_link_pack24_if.slave bus
);
  localparam int BIT_CYC  = CLOCK_RATE / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t        r_tx_st, w_tx_st_nx;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nx;
  logic [2:0]    r_tx_bit, w_tx_bit_nx;
  logic [7:0]    r_tx_sh, w_tx_sh_nx;
  logic          w_tx_end;
  logic          w_tx_out;

  assign w_tx_end = (r_tx_cnt == CW'(BIT_CYC - 1));

  // TX state register; reset drops straight back to idle so the line goes high at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_st  <= S_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
    end else begin
      r_tx_st  <= w_tx_st_nx;
      r_tx_cnt <= w_tx_cnt_nx;
      r_tx_bit <= w_tx_bit_nx;
      r_tx_sh  <= w_tx_sh_nx;
    end
  end

  // TX next state: the byte is shifted right so bit 0 is always the bit on the line
  always_comb begin
    w_tx_st_nx  = r_tx_st;
    w_tx_cnt_nx = r_tx_cnt;
    w_tx_bit_nx = r_tx_bit;
    w_tx_sh_nx  = r_tx_sh;
    case (r_tx_st)
      S_IDLE: begin
        if (enable && bus.tx_valid) begin
          w_tx_st_nx  = S_START;
          w_tx_cnt_nx = '0;
          w_tx_sh_nx  = bus.tx_in;
        end
      end
      S_START: begin
        if (w_tx_end) begin
          w_tx_st_nx  = S_DATA;
          w_tx_cnt_nx = '0;
          w_tx_bit_nx = '0;
        end else begin
          w_tx_cnt_nx = r_tx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_tx_end) begin
          w_tx_cnt_nx = '0;
          w_tx_sh_nx  = {1'b0, r_tx_sh[7:1]};
          if (r_tx_bit == 3'd7) w_tx_st_nx  = S_STOP;
          else                  w_tx_bit_nx = r_tx_bit + 3'd1;
        end else begin
          w_tx_cnt_nx = r_tx_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (w_tx_end) begin
          w_tx_st_nx  = S_IDLE;
          w_tx_cnt_nx = '0;
        end else begin
          w_tx_cnt_nx = r_tx_cnt + CW'(1);
        end
      end
      default: w_tx_st_nx = S_IDLE;
    endcase
  end

  // Line level decoded from the registered state only
  always_comb begin
    w_tx_out = 1'b1;
    case (r_tx_st)
      S_START: w_tx_out = 1'b0;
      S_DATA:  w_tx_out = r_tx_sh[0];
      default: w_tx_out = 1'b1;
    endcase
  end

  assign tx_out       = w_tx_out;
  assign bus.tx_ready = (r_tx_st == S_IDLE);

  // ---------------- receiver ----------------
  logic          r_sync1, r_sync2, r_sync3;
  state_t        r_rx_st, w_rx_st_nx;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nx;
  logic [2:0]    r_rx_bit, w_rx_bit_nx;
  logic [7:0]    r_rx_sh, w_rx_sh_nx;
  logic          w_rx_end, w_rx_half, w_rx_fall, w_rx_done;
  logic [7:0]    r_rx_out;
  logic          r_rx_valid, r_rx_ovr;

  assign w_rx_end  = (r_rx_cnt == CW'(BIT_CYC - 1));
  assign w_rx_half = (r_rx_cnt == CW'(HALF_CYC - 1));
  assign w_rx_fall = r_sync3 & ~r_sync2;

  // Two-flop synchroniser plus one extra stage for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // RX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_st  <= S_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
    end else begin
      r_rx_st  <= w_rx_st_nx;
      r_rx_cnt <= w_rx_cnt_nx;
      r_rx_bit <= w_rx_bit_nx;
      r_rx_sh  <= w_rx_sh_nx;
    end
  end

  // RX next state: half-bit wait centres all later samples in their bit cells
  always_comb begin
    w_rx_st_nx  = r_rx_st;
    w_rx_cnt_nx = r_rx_cnt;
    w_rx_bit_nx = r_rx_bit;
    w_rx_sh_nx  = r_rx_sh;
    w_rx_done   = 1'b0;
    case (r_rx_st)
      S_IDLE: begin
        if (enable && w_rx_fall) begin
          w_rx_st_nx  = S_START;
          w_rx_cnt_nx = '0;
        end
      end
      S_START: begin
        if (w_rx_half) begin
          w_rx_cnt_nx = '0;
          w_rx_bit_nx = '0;
          w_rx_st_nx  = r_sync2 ? S_IDLE : S_DATA;
        end else begin
          w_rx_cnt_nx = r_rx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_rx_end) begin
          w_rx_cnt_nx = '0;
          w_rx_sh_nx  = {r_sync2, r_rx_sh[7:1]};
          if (r_rx_bit == 3'd7) w_rx_st_nx  = S_STOP;
          else                  w_rx_bit_nx = r_rx_bit + 3'd1;
        end else begin
          w_rx_cnt_nx = r_rx_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (w_rx_end) begin
          w_rx_cnt_nx = '0;
          w_rx_st_nx  = S_IDLE;
          w_rx_done   = r_sync2;
        end else begin
          w_rx_cnt_nx = r_rx_cnt + CW'(1);
        end
      end
      default: w_rx_st_nx = S_IDLE;
    endcase
  end

  // Output byte register: a new byte beats a same-cycle consume; overrun is sticky
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_out   <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else if (w_rx_done) begin
      r_rx_out   <= r_rx_sh;
      r_rx_valid <= 1'b1;
      if (r_rx_valid && !bus.rx_ready) r_rx_ovr <= 1'b1;
    end else if (r_rx_valid && bus.rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign bus.rx_out   = r_rx_out;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_ovr   = r_rx_ovr;

  // ---------------- packer ----------------
  logic        r_vld_d;
  logic [1:0]  r_pk_cnt;
  logic [23:0] r_po;
  logic        r_ld;
  logic        w_pk_cap;

  assign w_pk_cap = r_rx_valid & ~r_vld_d;

  // Capture on the rising edge of rx_valid; a held-high valid counts as one byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_d  <= 1'b0;
      r_pk_cnt <= '0;
      r_po     <= '0;
      r_ld     <= 1'b0;
    end else begin
      r_vld_d <= r_rx_valid;
      r_ld    <= 1'b0;
      if (w_pk_cap) begin
        case (r_pk_cnt)
          2'd0: begin r_po[23:16] <= r_rx_out; r_pk_cnt <= 2'd1; end
          2'd1: begin r_po[15:8]  <= r_rx_out; r_pk_cnt <= 2'd2; end
          2'd2: begin r_po[7:0]   <= r_rx_out; r_pk_cnt <= 2'd0; r_ld <= 1'b1; end
          default: r_pk_cnt <= 2'd0;
        endcase
      end
    end
  end

  assign bus.po = r_po;
  assign bus.ld = r_ld;
endmodule

// File: tb/tb_uart_link_pack24.sv
// Scoreboard bench for uart_link_pack24: stimulus pushes expected TX bytes,
// RX bytes and packed words; independent monitors pop and compare.
module tb_uart_link_pack24;
  localparam int BIT_CYC = 33;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  logic rx_in, tx_out;

  uart_link_pack24_if bus();

  assign rx_in = loop ? tx_out : rx_drv;

  uart_link_pack24 #(.CLOCK_RATE(10000), .BAUD_RATE(300)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_in(rx_in), .tx_out(tx_out), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  q_tx[$];
  logic [7:0]  q_rx[$];
  logic [23:0] q_po[$];
  bit tx_mon_on = 1'b1;
  bit seen_vld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_ready(input int bound);
    int n = 0;
    while (!bus.tx_ready && n < bound) begin cyc(1); n++; end
    chk("tx_ready_timeout", 32'(bus.tx_ready), 32'd1);
  endtask

  // Hand one byte to the transmitter; optionally wait for the frame to finish
  task automatic send_byte(input logic [7:0] b, input bit wait_done);
    wait_tx_ready(400);
    bus.tx_valid = 1'b1;
    bus.tx_in    = b;
    cyc(1);
    bus.tx_valid = 1'b0;
    if (wait_done) wait_tx_ready(400);
  endtask

  // Drive one raw bit cell on rx_in while watching for any rx_valid
  task automatic raw_bit(input logic v);
    rx_drv = v;
    repeat (BIT_CYC) begin cyc(1); if (bus.rx_valid) seen_vld = 1'b1; end
  endtask

  // Serial decoder on tx_out: centre-samples each bit of a frame
  initial begin : tx_mon
    logic prev;
    logic [7:0] b;
    logic st, sp;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx_out === 1'b0) begin
        repeat (BIT_CYC/2) @(negedge clk);
        st = tx_out;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYC) @(negedge clk);
          b[i] = tx_out;
        end
        repeat (BIT_CYC) @(negedge clk);
        sp = tx_out;
        if (tx_mon_on) begin
          chk("tx_start_bit", 32'(st), 32'd0);
          chk("tx_stop_bit", 32'(sp), 32'd1);
          if (q_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got %0h expected none", b);
          end else chk("tx_byte", 32'(b), 32'(q_tx.pop_front()));
        end
      end
      prev = tx_out;
    end
  end

  // RX handshake monitor
  always @(negedge clk) begin
    if (!reset && bus.rx_valid && bus.rx_ready) begin
      if (q_rx.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected: got %0h expected none", bus.rx_out);
      end else chk("rx_byte", 32'(bus.rx_out), 32'(q_rx.pop_front()));
    end
  end

  // Packed word monitor
  always @(negedge clk) begin
    if (!reset && bus.ld) begin
      if (q_po.size() == 0) begin
        checks++; errors++;
        $display("FAIL ld_unexpected: got %0h expected none", bus.po);
      end else chk("po_word", 32'(bus.po), 32'(q_po.pop_front()));
    end
  end

  initial begin
    int n;
    bit ok;
    bus.tx_valid = 1'b0;
    bus.tx_in    = 8'h00;
    bus.rx_ready = 1'b1;
    cyc(3);
    // reset values
    chk("rst_tx_out",   32'(tx_out), 32'd1);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_rx_out",   32'(bus.rx_out), 32'd0);
    chk("rst_rx_ovr",   32'(bus.rx_ovr), 32'd0);
    chk("rst_po",       32'(bus.po), 32'd0);
    chk("rst_ld",       32'(bus.ld), 32'd0);
    reset = 1'b0;
    cyc(3);

    // T1: single 0xAA frame, no loopback; tx_ready low for exactly ten bit times
    q_tx.push_back(8'hAA);
    bus.tx_valid = 1'b1; bus.tx_in = 8'hAA;
    cyc(1);
    bus.tx_valid = 1'b0;
    chk("t1_tx_out_start", 32'(tx_out), 32'd0);
    chk("t1_tx_ready_drop", 32'(bus.tx_ready), 32'd0);
    n = 0;
    while (!bus.tx_ready && n < 400) begin cyc(1); n++; end
    chk("t1_tx_ready_low_cycles", 32'(n), 32'd330);
    cyc(5);

    // T2: loopback AA 01 AA -> one packed word
    loop = 1'b1;
    foreach (q_rx[i]) q_rx.delete(i);
    q_tx.push_back(8'hAA); q_rx.push_back(8'hAA);
    q_tx.push_back(8'h01); q_rx.push_back(8'h01);
    q_tx.push_back(8'hAA); q_rx.push_back(8'hAA);
    q_po.push_back(24'hAA01AA);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1);
    cyc(20);
    chk("t2_po_hold", 32'(bus.po), 32'hAA01AA);

    // T3: consumer stalled, two bytes -> overrun, packer counts one byte
    bus.rx_ready = 1'b0;
    q_tx.push_back(8'h55);
    q_tx.push_back(8'h33);
    send_byte(8'h55, 1'b1);
    send_byte(8'h33, 1'b1);
    cyc(20);
    chk("t3_rx_valid", 32'(bus.rx_valid), 32'd1);
    chk("t3_rx_out",   32'(bus.rx_out), 32'h33);
    chk("t3_rx_ovr",   32'(bus.rx_ovr), 32'd1);
    chk("t3_po_partial", 32'(bus.po), 32'h5501AA);
    q_rx.push_back(8'h33);
    bus.rx_ready = 1'b1;
    cyc(3);
    chk("t3_rx_valid_clear", 32'(bus.rx_valid), 32'd0);

    // T4: 0x12 with stop bit forced low -> discarded
    loop = 1'b0;
    seen_vld = 1'b0;
    raw_bit(1'b0);
    for (int i = 0; i < 8; i++) raw_bit(1'((8'h12 >> i) & 8'h01));
    raw_bit(1'b0);
    raw_bit(1'b1);
    raw_bit(1'b1);
    chk("t4_no_rx_valid", 32'(seen_vld), 32'd0);
    chk("t4_po_unchanged", 32'(bus.po), 32'h5501AA);

    // T5: 0x3C then 0xC3 with 0xFF offered mid-frame; word proves T3/T4 counting
    loop = 1'b1;
    q_tx.push_back(8'h3C); q_rx.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    q_tx.push_back(8'hC3); q_rx.push_back(8'hC3);
    q_po.push_back(24'h553CC3);
    send_byte(8'hC3, 1'b0);
    cyc(100);
    bus.tx_valid = 1'b1; bus.tx_in = 8'hFF;
    ok = 1'b1;
    repeat (5) begin cyc(1); if (bus.tx_ready) ok = 1'b0; end
    bus.tx_valid = 1'b0;
    chk("t5_tx_ready_low", 32'(ok), 32'd1);
    wait_tx_ready(400);
    cyc(20);

    // T6: one byte into the packer, then reset mid TX/RX frame
    q_tx.push_back(8'h5A); q_rx.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    cyc(20);
    chk("t6_po_partial", 32'(bus.po), 32'h5A3CC3);
    tx_mon_on = 1'b0;
    send_byte(8'h77, 1'b0);
    cyc(150);
    reset = 1'b1;
    #1;
    chk("t6_tx_out",   32'(tx_out), 32'd1);
    chk("t6_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("t6_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("t6_po",       32'(bus.po), 32'd0);
    chk("t6_rx_ovr",   32'(bus.rx_ovr), 32'd0);
    chk("t6_ld",       32'(bus.ld), 32'd0);
    cyc(3);
    reset = 1'b0;
    cyc(400);
    tx_mon_on = 1'b1;
    // packer count must restart at zero
    q_tx.push_back(8'h11); q_rx.push_back(8'h11);
    q_tx.push_back(8'h22); q_rx.push_back(8'h22);
    q_tx.push_back(8'h33); q_rx.push_back(8'h33);
    q_po.push_back(24'h112233);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    cyc(40);

    chk("tx_queue_drained", 32'(q_tx.size()), 32'd0);
    chk("rx_queue_drained", 32'(q_rx.size()), 32'd0);
    chk("po_queue_drained", 32'(q_po.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
